// File: rtl/mealy_driver_if.sv
// Signal bundle between a controlling agent (master) and the mealy_driver (slave).
// CNT_W must match the mealy_driver instance that uses this bundle.
interface mealy_driver_if #(
    parameter int CNT_W = 8
);
    logic             clr;
    logic             wr_en;
    logic [1:0]       wr_data;
    logic             start;
    logic [1:0]       drv_data;
    logic             dut_out;
    logic             busy;
    logic             done;
    logic             mismatch;
    logic [CNT_W-1:0] err_cnt;
    logic             ovf;
    logic [2:0]       model_state;

    modport master (
        output clr, wr_en, wr_data, start, dut_out,
        input  drv_data, busy, done, mismatch, err_cnt, ovf, model_state
    );

    modport slave (
        input  clr, wr_en, wr_data, start, dut_out,
        output drv_data, busy, done, mismatch, err_cnt, ovf, model_state
    );
endinterface

// File: rtl/mealy_driver.sv
// Replays a programmed 2-bit symbol sequence into a Mealy detector and checks its
// output against an internal cycle-exact model of that detector.
module mealy_driver #(
    parameter int         DEPTH    = 8,
    parameter int         CNT_W    = 8,
    parameter logic [1:0] IDLE_SYM = 2'b00
) (
    input logic           clock,
    input logic           reset,
    mealy_driver_if.slave bus
);
    localparam int                PTR_W  = $clog2(DEPTH);
    localparam int                FILL_W = PTR_W + 1;
    localparam logic [FILL_W-1:0] FULL   = FILL_W'(DEPTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [2:0] M_S0 = 3'd0;
    localparam logic [2:0] M_S1 = 3'd1;
    localparam logic [2:0] M_S2 = 3'd2;
    localparam logic [2:0] M_S3 = 3'd3;
    localparam logic [2:0] M_S4 = 3'd4;

    logic [1:0]        state_q, state_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [2:0]        model_q, model_d;
    logic              mismatch_q, mismatch_d;
    logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
    logic              ovf_q, ovf_d;
    logic [1:0]        mem_q [DEPTH];

    logic [1:0] drv_sym;
    logic       model_out;
    logic       clr_ok, wr_try, wr_ok, last_sym;

    assign drv_sym = (state_q == ST_RUN) ? mem_q[ptr_q] : IDLE_SYM;

    // Detector model: runs in every FSM state so it stays in lockstep with the real detector.
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        model_d   = M_S0;
        model_out = 1'b0;
        case (model_q)
            M_S0: begin
                model_out = (drv_sym != 2'b00);
                case (drv_sym)
                    2'b00:   model_d = M_S0;
                    2'b01:   model_d = M_S4;
                    2'b10:   model_d = M_S1;
                    default: model_d = M_S2;
                endcase
            end
            M_S1: model_d = (drv_sym == 2'b00) ? M_S0 : ((drv_sym == 2'b10) ? M_S2 : M_S1);
            M_S2: begin
                model_out = drv_sym[1];
                model_d   = drv_sym[1] ? M_S3 : M_S1;
            end
            M_S3: begin
                model_out = 1'b1;
                model_d   = drv_sym[0] ? M_S4 : M_S3;
            end
            M_S4: begin
                model_out = drv_sym[1];
                model_d   = (drv_sym == 2'b11) ? M_S4 : M_S0;
            end
            default: begin
                model_d   = M_S0;
                model_out = 1'b0;
            end
        endcase
    end

    // Buffer bookkeeping: clr beats a same-cycle write, and both are frozen during a run.
    always_comb begin
        clr_ok   = bus.clr && (state_q != ST_RUN);
        wr_try   = bus.wr_en && (state_q != ST_RUN) && !clr_ok;
        wr_ok    = wr_try && (fill_q != FULL);
        fill_d   = clr_ok ? '0 : (wr_ok ? fill_q + FILL_W'(1) : fill_q);
        ovf_d    = clr_ok ? 1'b0 : (ovf_q | (wr_try && (fill_q == FULL)));
        last_sym = ({1'b0, ptr_q} == fill_q - FILL_W'(1));
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        err_cnt_d  = err_cnt_q;
        mismatch_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    // fill_d so that a write landing on the start edge joins this run
                    err_cnt_d = '0;
                    ptr_d     = '0;
                    state_d   = (fill_d != '0) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                mismatch_d = (bus.dut_out != model_out);
                if (mismatch_d && (err_cnt_q != '1)) begin
                    err_cnt_d = err_cnt_q + CNT_W'(1);
                end
                ptr_d = ptr_q + PTR_W'(1);
                if (last_sym) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            fill_q     <= '0;
            ptr_q      <= '0;
            model_q    <= M_S0;
            mismatch_q <= 1'b0;
            err_cnt_q  <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            fill_q     <= fill_d;
            ptr_q      <= ptr_d;
            model_q    <= model_d;
            mismatch_q <= mismatch_d;
            err_cnt_q  <= err_cnt_d;
            ovf_q      <= ovf_d;
        end
    end

    // NOTE: the symbol store has no reset; fill_q = 0 already marks every entry as invalid.
    always_ff @(posedge clock) begin
        if (wr_ok) begin
            mem_q[fill_q[PTR_W-1:0]] <= bus.wr_data;
        end
    end

    assign bus.drv_data    = drv_sym;
    assign bus.busy        = (state_q == ST_RUN);
    assign bus.done        = (state_q == ST_DONE);
    assign bus.mismatch    = mismatch_q;
    assign bus.err_cnt     = err_cnt_q;
    assign bus.ovf         = ovf_q;
    assign bus.model_state = model_q;
endmodule

// File: tb/tb_mealy_driver.sv
// Randomized self-checking bench for mealy_driver; the detector is modelled as a lookup
// table and the program buffer as a queue, with the bench acting as the detector.
module tb_mealy_driver;
    localparam int DEPTH   = 8;
    localparam int CNT_W   = 8;
    localparam int SAT_MAX = (1 << CNT_W) - 1;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    mealy_driver_if #(.CNT_W(CNT_W)) bus ();

    mealy_driver #(.DEPTH(DEPTH), .CNT_W(CNT_W), .IDLE_SYM(2'b00)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    // Detector transition/output tables, rows = state S0..S4, columns = input symbol 00..11.
    int nxt_tab [5][4] = '{'{0, 4, 1, 2}, '{0, 1, 2, 1}, '{1, 1, 3, 3}, '{3, 4, 3, 4}, '{0, 0, 0, 4}};
    int out_tab [5][4] = '{'{0, 1, 1, 1}, '{0, 0, 0, 0}, '{0, 0, 1, 1}, '{1, 1, 1, 1}, '{0, 0, 1, 1}};

    logic [1:0] prog [$];
    int         ref_st  = 0;
    bit         ref_ovf = 1'b0;

    task automatic idle_cycle();
        @(posedge clock);
        ref_st = nxt_tab[ref_st][0];
        @(negedge clock);
    endtask

    task automatic write_sym(input logic [1:0] s);
        bus.wr_en   = 1'b1;
        bus.wr_data = s;
        @(posedge clock);
        if (prog.size() < DEPTH) prog.push_back(s);
        else ref_ovf = 1'b1;
        ref_st = nxt_tab[ref_st][0];
        @(negedge clock);
        bus.wr_en = 1'b0;
    endtask

    task automatic clear_buf();
        bus.clr = 1'b1;
        @(posedge clock);
        prog.delete();
        ref_ovf = 1'b0;
        ref_st  = nxt_tab[ref_st][0];
        @(negedge clock);
        bus.clr = 1'b0;
    endtask

    // Starts a run of the current program and checks it cycle by cycle.
    // force0: detector output stuck at 0; otherwise correct output XOR inj[k].
    task automatic replay(input string tag, input logic [7:0] inj, input bit force0,
                          input bit with_wr, input logic [1:0] wsym);
        int n;
        int exp_err   = 0;
        bit prev_miss = 1'b0;
        bit miss;
        int exp_out;
        bus.start   = 1'b1;
        bus.wr_en   = with_wr;
        bus.wr_data = wsym;
        @(posedge clock);
        if (with_wr) begin
            if (prog.size() < DEPTH) prog.push_back(wsym);
            else ref_ovf = 1'b1;
        end
        ref_st = nxt_tab[ref_st][0];
        @(negedge clock);
        bus.start = 1'b0;
        bus.wr_en = 1'b0;
        n = prog.size();
        for (int k = 0; k < n; k++) begin
            checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL %s busy k=%0d got %b want 1", tag, k, bus.busy); end
            checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL %s done_early k=%0d got %b want 0", tag, k, bus.done); end
            checks++; if (bus.drv_data !== prog[k]) begin errors++; $display("FAIL %s drv_data k=%0d got %b want %b", tag, k, bus.drv_data, prog[k]); end
            checks++; if (bus.model_state !== 3'(ref_st)) begin errors++; $display("FAIL %s model_state k=%0d got %0d want %0d", tag, k, bus.model_state, ref_st); end
            checks++; if (bus.mismatch !== prev_miss) begin errors++; $display("FAIL %s mismatch k=%0d got %b want %b", tag, k, bus.mismatch, prev_miss); end
            exp_out = out_tab[ref_st][prog[k]];
            if (force0) begin
                bus.dut_out = 1'b0;
                miss = (exp_out != 0);
            end else begin
                bus.dut_out = 1'(exp_out) ^ inj[k];
                miss = inj[k];
            end
            if (miss && exp_err < SAT_MAX) exp_err++;
            @(posedge clock);
            ref_st = nxt_tab[ref_st][prog[k]];
            @(negedge clock);
            prev_miss = miss;
        end
        bus.dut_out = 1'b0;
        checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL %s done got %b want 1", tag, bus.done); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL %s busy_end got %b want 0", tag, bus.busy); end
        checks++; if (bus.drv_data !== 2'b00) begin errors++; $display("FAIL %s drv_idle got %b want 00", tag, bus.drv_data); end
        checks++; if (bus.mismatch !== prev_miss) begin errors++; $display("FAIL %s mismatch_last got %b want %b", tag, bus.mismatch, prev_miss); end
        checks++; if (bus.err_cnt !== CNT_W'(exp_err)) begin errors++; $display("FAIL %s err_cnt got %0d want %0d", tag, bus.err_cnt, exp_err); end
        checks++; if (bus.model_state !== 3'(ref_st)) begin errors++; $display("FAIL %s model_state_done got %0d want %0d", tag, bus.model_state, ref_st); end
        idle_cycle();
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL %s done_pulse got %b want 0", tag, bus.done); end
        checks++; if (bus.mismatch !== 1'b0) begin errors++; $display("FAIL %s mismatch_idle got %b want 0", tag, bus.mismatch); end
        checks++; if (bus.err_cnt !== CNT_W'(exp_err)) begin errors++; $display("FAIL %s err_hold got %0d want %0d", tag, bus.err_cnt, exp_err); end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clock);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset busy got %b want 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset done got %b want 0", bus.done); end
        checks++; if (bus.mismatch !== 1'b0) begin errors++; $display("FAIL reset mismatch got %b want 0", bus.mismatch); end
        checks++; if (bus.ovf !== 1'b0) begin errors++; $display("FAIL reset ovf got %b want 0", bus.ovf); end
        checks++; if (bus.err_cnt !== '0) begin errors++; $display("FAIL reset err_cnt got %0d want 0", bus.err_cnt); end
        checks++; if (bus.model_state !== 3'd0) begin errors++; $display("FAIL reset model_state got %0d want 0", bus.model_state); end
        checks++; if (bus.drv_data !== 2'b00) begin errors++; $display("FAIL reset drv_data got %b want 00", bus.drv_data); end
        reset = 1'b1;
        idle_cycle();
    endtask

    task automatic test_program();
        write_sym(2'b10); write_sym(2'b10); write_sym(2'b11); write_sym(2'b01); write_sym(2'b00);
        replay("program", 8'h00, 1'b0, 1'b0, 2'b00);
    endtask

    task automatic test_forced_zero();
        replay("forced0", 8'h00, 1'b1, 1'b0, 2'b00);
        checks++; if (bus.err_cnt !== CNT_W'(3)) begin errors++; $display("FAIL forced0 err_cnt3 got %0d want 3", bus.err_cnt); end
    endtask

    task automatic test_overflow();
        clear_buf();
        for (int i = 0; i < DEPTH; i++) write_sym(2'($urandom_range(0, 3)));
        checks++; if (bus.ovf !== 1'b0) begin errors++; $display("FAIL ovf_full got %b want 0", bus.ovf); end
        write_sym(2'($urandom_range(0, 3)));
        checks++; if (bus.ovf !== ref_ovf) begin errors++; $display("FAIL ovf_set got %b want %b", bus.ovf, ref_ovf); end
        replay("ovf_run", 8'($urandom), 1'b0, 1'b0, 2'b00);
        checks++; if (bus.ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", bus.ovf); end
        clear_buf();
        checks++; if (bus.ovf !== 1'b0) begin errors++; $display("FAIL ovf_clr got %b want 0", bus.ovf); end
        replay("ovf_cleared", 8'h00, 1'b0, 1'b0, 2'b00);
    endtask

    task automatic test_empty_start();
        clear_buf();
        replay("empty", 8'h00, 1'b0, 1'b0, 2'b00);
    endtask

    task automatic test_reset_mid_run();
        clear_buf();
        write_sym(2'b11); write_sym(2'b11);
        bus.start = 1'b1;
        @(posedge clock);
        ref_st = nxt_tab[ref_st][0];
        @(negedge clock);
        bus.start   = 1'b0;
        bus.dut_out = 1'(out_tab[ref_st][3]);
        @(posedge clock);
        ref_st = nxt_tab[ref_st][3];
        @(negedge clock);
        checks++; if (bus.drv_data !== 2'b11) begin errors++; $display("FAIL midrst second_sym got %b want 11", bus.drv_data); end
        #2 reset = 1'b0;
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrst busy got %b want 0", bus.busy); end
        checks++; if (bus.model_state !== 3'd0) begin errors++; $display("FAIL midrst model_state got %0d want 0", bus.model_state); end
        checks++; if (bus.drv_data !== 2'b00) begin errors++; $display("FAIL midrst drv_data got %b want 00", bus.drv_data); end
        @(posedge clock);
        @(negedge clock);
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL midrst done got %b want 0", bus.done); end
        bus.dut_out = 1'b0;
        reset = 1'b1;
        prog.delete();
        ref_st  = 0;
        ref_ovf = 1'b0;
        idle_cycle();
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL midrst no_done got %b want 0", bus.done); end
        replay("after_reset", 8'h00, 1'b0, 1'b0, 2'b00);
    endtask

    task automatic test_back_to_back();
        clear_buf();
        write_sym(2'b01);
        bus.start = 1'b1;
        @(posedge clock);
        ref_st = nxt_tab[ref_st][0];
        @(negedge clock);
        checks++; if (bus.drv_data !== 2'b01) begin errors++; $display("FAIL b2b drv_data got %b want 01", bus.drv_data); end
        bus.dut_out = 1'(out_tab[ref_st][1]);
        @(posedge clock);
        ref_st = nxt_tab[ref_st][1];
        @(negedge clock);
        bus.start   = 1'b0;
        bus.dut_out = 1'b0;
        checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL b2b done got %b want 1", bus.done); end
        idle_cycle();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL b2b ignored_start got %b want 0", bus.busy); end
        checks++; if (bus.model_state !== 3'd0) begin errors++; $display("FAIL b2b back_to_s0 got %0d want 0", bus.model_state); end
        replay("restart", 8'h00, 1'b0, 1'b0, 2'b00);
        replay("start_wr", 8'h00, 1'b0, 1'b1, 2'($urandom_range(0, 3)));
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            clear_buf();
            for (int i = 0; i < int'($urandom_range(1, DEPTH)); i++) write_sym(2'($urandom_range(0, 3)));
            repeat ($urandom_range(0, 3)) idle_cycle();
            replay("rand_a", 8'($urandom), 1'b0, 1'b0, 2'b00);
            replay("rand_b", 8'($urandom), 1'b0, 1'b0, 2'b00);
        end
    endtask

    initial begin
        bus.clr     = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_data = 2'b00;
        bus.start   = 1'b0;
        bus.dut_out = 1'b0;
        test_reset();
        test_program();
        test_forced_zero();
        test_overflow();
        test_empty_start();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
